// File: rtl/main_fsm_if.sv
// Control bundle between the RV32I main FSM and the datapath/memory.
// Handshake: the FSM holds its memory request (adr_src, mem_write, fetch enables) stable and the
//   memory asserts mem_ready in the cycle it completes the access; the FSM advances only on mem_ready=1.
interface main_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       pc_update;
  logic       branch;
  logic       reg_write;
  logic       mem_write;
  logic       ir_write;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       retire;
  logic       illegal_op;

  modport master (
    output op, mem_ready,
    input  pc_update, branch, reg_write, mem_write, ir_write, adr_src,
           result_src, alu_src_a, alu_src_b, alu_op, retire, illegal_op
  );

  modport slave (
    input  op, mem_ready,
    output pc_update, branch, reg_write, mem_write, ir_write, adr_src,
           result_src, alu_src_a, alu_src_b, alu_op, retire, illegal_op
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback and
// decodes all datapath enables and selects from the state register.
module main_fsm (
  input  logic        clk,
  input  logic        reset_n,
  main_fsm_if.slave   bus,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  state_t state, next_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  assign dbg_state = state;

  always_comb begin
    next_state     = state;
    bus.pc_update  = 1'b0;
    bus.branch     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.retire     = 1'b0;
    bus.illegal_op = 1'b0;

    unique case (state)
      S_FETCH: begin
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        // mem_ready may already be high while reset is held; keep the loads off until release.
        bus.ir_write   = bus.mem_ready & reset_n;
        bus.pc_update  = bus.mem_ready & reset_n;
        if (bus.mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        case (bus.op)
          7'b0000011, 7'b0100011: next_state = S_MEMADR;
          7'b0110011:             next_state = S_EXECR;
          7'b0010011:             next_state = S_EXECI;
          7'b1100011:             next_state = S_BRANCH;
          7'b1101111:             next_state = S_JAL;
          7'b1100111:             next_state = S_JALR;
          7'b0110111:             next_state = S_LUI;
          7'b0010111:             next_state = S_AUIPC;
          default:                next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        next_state    = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.adr_src = 1'b1;
        if (bus.mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
        bus.retire     = 1'b1;
        next_state     = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
        bus.retire    = bus.mem_ready;
        if (bus.mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
        next_state    = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
        next_state    = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b01;
        bus.branch    = 1'b1;
        bus.retire    = 1'b1;
        next_state    = S_FETCH;
      end
      S_JAL, S_JALRPC: begin
        // ALUOut already holds the target; the ALU forms OldPC+4 for the link writeback.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_update = 1'b1;
        next_state    = S_ALUWB;
      end
      S_JALR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
        next_state    = S_JALRPC;
      end
      S_LUI: begin
        bus.alu_src_a = 2'b11;
        bus.alu_src_b = 2'b01;
        next_state    = S_ALUWB;
      end
      S_AUIPC: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        next_state    = S_ALUWB;
      end
      S_TRAP: begin
        bus.illegal_op = 1'b1;
      end
      default: next_state = S_TRAP;
    endcase
  end

endmodule
